dmg_bus_arbiter: RTL and testbench
==================================

// Module: dmg_bus_arbiter
// PURPOSE
//  Shares the external memory bus (MREQ/RD/WR, 16-bit address, 8-bit data) between the SM83 core
//  and a DMA requester. Grants one requester at a time, latches its command, and sequences a fixed
//  ADDR/WAIT/ACK access with programmable wait states. Sits between SM83Core/DMA and the memory/HW model.
// PARAMETERS
//  AW           16  address width
//  DW           8   data width
//  WAIT_CYCLES  2   cycles RD/WR held asserted per access; legal range 1..15
//  DMA_PRIORITY 1   1: DMA wins every tie; 0: round-robin on ties (last-served loses)
// PORTS
//  CLK        in   1   single clock; all state updates on posedge
//  RESET      in   1   asynchronous, active-high reset
//  cpu_req    in   1   CPU access request; held until cpu_ack
//  cpu_wr     in   1   1=write, 0=read
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_rdata  out  DW  read data; valid in the cpu_ack cycle, held until next CPU read completes
//  cpu_ack    out  1   one-cycle completion pulse
//  dma_req    in   1   DMA access request; held until dma_ack
//  dma_wr     in   1   1=write, 0=read
//  dma_addr   in   AW  DMA address
//  dma_wdata  in   DW  DMA write data
//  dma_rdata  out  DW  read data; same rules as cpu_rdata
//  dma_ack    out  1   one-cycle completion pulse
//  mem_mreq   out  1   memory request (ADDR and WAIT states)
//  mem_rd     out  1   read strobe (WAIT state, read access)
//  mem_wr     out  1   write strobe (WAIT state, write access)
//  mem_addr   out  AW  latched access address
//  mem_dout   out  DW  latched write data
//  mem_oe     out  1   data-bus drive enable (ADDR and WAIT, write access); top level tristates with it
//  mem_din    in   DW  data from memory; sampled on the last WAIT edge
//  busy       out  1   1 in any state except IDLE
//  owner      out  1   0=CPU, 1=DMA; owner of current/last access
// BEHAVIOUR
//  Reset (async): FSM=IDLE, wait counter=0, every output 0 (rdata regs, mem_addr, mem_dout, owner).
//  FSM: IDLE -> ADDR -> WAIT -> ACK -> IDLE. Exactly one state per cycle except WAIT.
//  IDLE: on edge with any req: pick winner, latch its wr/addr/wdata into command regs, owner<=winner,
//   go ADDR. Requester inputs are ignored after the grant edge.
//  Arbitration: only one req -> it wins. Both: DMA_PRIORITY=1 -> DMA; DMA_PRIORITY=0 -> requester
//   that is not `owner` (after reset owner=0, so DMA wins the first tie).
//  ADDR (1 cycle): mem_mreq=1, mem_addr/mem_dout valid, mem_oe=wr. Load counter=WAIT_CYCLES-1. -> WAIT.
//  WAIT (WAIT_CYCLES cycles): mem_mreq=1, mem_rd=~wr, mem_wr=wr, mem_oe=wr. Counter decrements each
//   edge; on edge with counter==0: if read, owner's rdata<=mem_din; -> ACK.
//  ACK (1 cycle): strobes/mreq/oe=0; ack of owner=1, other ack=0. -> IDLE unconditionally.
//  Latency: req first seen at edge k -> ack high in cycle k+2+WAIT_CYCLES (cycle after edge k = k+1).
//   One dead IDLE cycle between consecutive accesses; max throughput 1 access / (WAIT_CYCLES+3).
//  Requester must drop req in the cycle after ack; req still high in IDLE is a new request.
//  mem_addr/mem_dout hold last values in IDLE/ACK (no glitch to 0); non-owner rdata never changes.
//  Write access never changes either rdata. Req dropped mid-access: access completes, ack still pulses.
//  Reset mid-access: strobes fall immediately (async), no ack, no rdata update; IDLE after release.
//  WAIT_CYCLES outside 1..15: elaboration error ($error in generate).
// TESTING
//  1 CPU read W=2: cpu_req, addr 16'h0150, mem_din=8'hA5 -> mreq cycles 1-3, rd cycles 2-3,
//    cpu_ack only in cycle 4, cpu_rdata=8'hA5, dma_ack never high.
//  2 DMA write addr 16'hFE00, data 8'h3C -> mem_wr=1 and mem_oe=1 with mem_dout=8'h3C for 2 cycles,
//    dma_ack pulse once, cpu_rdata/dma_rdata unchanged.
//  3 Tie, DMA_PRIORITY=0, both reqs held: grant order DMA,CPU,DMA,CPU; owner toggles; 5-cycle period.
//  4 Tie, DMA_PRIORITY=1, both held for 3 accesses: all 3 granted to DMA, cpu_ack never high.
//  5 RESET asserted during WAIT of a read with mem_din=8'hFF -> mem_rd/mem_mreq 0 same cycle, no ack,
//    rdata stays 8'h00; after release a fresh CPU read completes normally.
//  6 Change cpu_addr to 16'h1234 in the ADDR cycle of a read to 16'h0100 -> mem_addr stays 16'h0100.

Source files
------------

// File: rtl/dmg_bus_arbiter.sv
// Memory bus arbiter between the SM83 core and DMA.
// Fixed ADDR/WAIT/ACK access sequence with programmable wait states.
module dmg_bus_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 8,
  parameter int WAIT_CYCLES  = 2,
  parameter int DMA_PRIORITY = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_wr,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_mreq,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dout,
  output logic          mem_oe,
  input  logic [DW-1:0] mem_din,
  output logic          busy,
  output logic          owner
);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_ACK
  } state_t;

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_owner;
  logic          r_cmd_wr;
  logic          r_mreq;
  logic          r_rd;
  logic          r_mem_wr;
  logic          r_oe;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_dout;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dma_rdata;
  logic          r_cpu_ack;
  logic          r_dma_ack;

  logic          w_any;
  logic          w_pick_dma;
  logic          w_sel_wr;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  // On a tie, round-robin hands the bus to whoever did not own it last.
  assign w_any      = cpu_req | dma_req;
  assign w_pick_dma = (cpu_req && dma_req)
                    ? ((DMA_PRIORITY != 0) ? 1'b1 : ~r_owner)
                    : dma_req;
  assign w_sel_wr    = w_pick_dma ? dma_wr    : cpu_wr;
  assign w_sel_addr  = w_pick_dma ? dma_addr  : cpu_addr;
  assign w_sel_wdata = w_pick_dma ? dma_wdata : cpu_wdata;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner     <= 1'b0;
      r_cmd_wr    <= 1'b0;
      r_mreq      <= 1'b0;
      r_rd        <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_oe        <= 1'b0;
      r_addr      <= '0;
      r_dout      <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state  <= S_ADDR;
            r_owner  <= w_pick_dma;
            r_cmd_wr <= w_sel_wr;
            r_addr   <= w_sel_addr;
            r_dout   <= w_sel_wdata;
            r_mreq   <= 1'b1;
            r_oe     <= w_sel_wr;
          end
        end
        S_ADDR: begin
          r_state  <= S_WAIT;
          r_cnt    <= LP_LAST;
          r_rd     <= ~r_cmd_wr;
          r_mem_wr <= r_cmd_wr;
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state  <= S_ACK;
            r_mreq   <= 1'b0;
            r_rd     <= 1'b0;
            r_mem_wr <= 1'b0;
            r_oe     <= 1'b0;
            if (r_owner) r_dma_ack <= 1'b1;
            else         r_cpu_ack <= 1'b1;
            if (!r_cmd_wr) begin
              if (r_owner) r_dma_rdata <= mem_din;
              else         r_cpu_rdata <= mem_din;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ack   = r_cpu_ack;
  assign dma_rdata = r_dma_rdata;
  assign dma_ack   = r_dma_ack;
  assign mem_mreq  = r_mreq;
  assign mem_rd    = r_rd;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_addr;
  assign mem_dout  = r_dout;
  assign mem_oe    = r_oe;
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;

endmodule

// File: tb/tb_dmg_bus_arbiter.sv
// Scoreboard bench for dmg_bus_arbiter: round-robin instance (a)
// and DMA-priority instance (b), directed vectors.
module tb_dmg_bus_arbiter;

  localparam int W = 2;

  logic        CLK = 1'b0;
  logic        RESET;

  logic        a_cpu_req, a_cpu_wr, a_dma_req, a_dma_wr;
  logic [15:0] a_cpu_addr, a_dma_addr, a_mem_addr;
  logic [7:0]  a_cpu_wdata, a_dma_wdata, a_cpu_rdata, a_dma_rdata;
  logic [7:0]  a_mem_dout, a_mem_din;
  logic        a_cpu_ack, a_dma_ack, a_mem_mreq, a_mem_rd;
  logic        a_mem_wr, a_mem_oe, a_busy, a_owner;

  logic        b_cpu_req, b_cpu_wr, b_dma_req, b_dma_wr;
  logic [15:0] b_cpu_addr, b_dma_addr, b_mem_addr;
  logic [7:0]  b_cpu_wdata, b_dma_wdata, b_cpu_rdata, b_dma_rdata;
  logic [7:0]  b_mem_dout, b_mem_din;
  logic        b_cpu_ack, b_dma_ack, b_mem_mreq, b_mem_rd;
  logic        b_mem_wr, b_mem_oe, b_busy, b_owner;

  logic        din_force;
  logic [7:0]  din_val;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  function automatic logic [7:0] mfn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign a_mem_din = din_force ? din_val : mfn(a_mem_addr);
  assign b_mem_din = mfn(b_mem_addr);

  dmg_bus_arbiter #(
    .WAIT_CYCLES(W), .DMA_PRIORITY(0)
  ) u_dut_a (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(a_cpu_req), .cpu_wr(a_cpu_wr),
    .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_ack(a_cpu_ack),
    .dma_req(a_dma_req), .dma_wr(a_dma_wr),
    .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
    .dma_rdata(a_dma_rdata), .dma_ack(a_dma_ack),
    .mem_mreq(a_mem_mreq), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
    .mem_addr(a_mem_addr), .mem_dout(a_mem_dout), .mem_oe(a_mem_oe),
    .mem_din(a_mem_din), .busy(a_busy), .owner(a_owner)
  );

  dmg_bus_arbiter #(
    .WAIT_CYCLES(W), .DMA_PRIORITY(1)
  ) u_dut_b (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(b_cpu_req), .cpu_wr(b_cpu_wr),
    .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack),
    .dma_req(b_dma_req), .dma_wr(b_dma_wr),
    .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
    .mem_mreq(b_mem_mreq), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .mem_addr(b_mem_addr), .mem_dout(b_mem_dout), .mem_oe(b_mem_oe),
    .mem_din(b_mem_din), .busy(b_busy), .owner(b_owner)
  );

  typedef struct {
    logic        who;
    logic [7:0]  cpu_rd;
    logic [7:0]  dma_rd;
  } ack_t;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  dout;
  } cmd_t;

  ack_t qa_ack[$];
  ack_t qb_ack[$];
  cmd_t qa_cmd[$];

  logic [7:0] m_cpu_rd;
  logic [7:0] m_dma_rd;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event not expected / not seen", nm);
  endtask

  // Monitor for instance a: command phase and completion.
  cmd_t cur;
  logic have = 1'b0;
  logic pa_mreq = 1'b0;
  logic pa_ack = 1'b0;
  int   n_mreq, n_rd, n_wr;

  always @(posedge CLK) begin
    ack_t e;
    #1;
    if (RESET) begin
      have = 1'b0;
    end else begin
      if (a_mem_mreq && !pa_mreq) begin
        if (qa_cmd.size() == 0) begin
          fail("a_unexpected_access");
        end else begin
          cur = qa_cmd.pop_front();
          have = 1'b1;
          n_mreq = 0; n_rd = 0; n_wr = 0;
          chk("a_addr_phase_strobe", {a_mem_rd, a_mem_wr}, 0);
        end
      end
      if (a_mem_mreq && have) begin
        n_mreq++;
        if (a_mem_rd) n_rd++;
        if (a_mem_wr) n_wr++;
        chk("a_mem_addr", a_mem_addr, cur.addr);
        chk("a_mem_oe", a_mem_oe, cur.wr);
        if (cur.wr) chk("a_mem_dout", a_mem_dout, cur.dout);
      end
      if (a_cpu_ack || a_dma_ack) begin
        if (pa_ack) fail("a_ack_width");
        if (qa_ack.size() == 0) begin
          fail("a_unexpected_ack");
        end else begin
          e = qa_ack.pop_front();
          chk("a_ack_sel", {a_dma_ack, a_cpu_ack},
              e.who ? 2'b10 : 2'b01);
          chk("a_owner", a_owner, e.who);
          chk("a_cpu_rdata", a_cpu_rdata, e.cpu_rd);
          chk("a_dma_rdata", a_dma_rdata, e.dma_rd);
          chk("a_ack_mreq_off",
              {a_mem_mreq, a_mem_rd, a_mem_wr, a_mem_oe}, 0);
          if (have) begin
            chk("a_mreq_cycles", n_mreq, W + 1);
            chk("a_strobe_cycles", cur.wr ? n_wr : n_rd, W);
            chk("a_wrong_strobe", cur.wr ? n_rd : n_wr, 0);
          end
        end
        have = 1'b0;
      end
    end
    pa_mreq = a_mem_mreq;
    pa_ack  = a_cpu_ack | a_dma_ack;
  end

  // Monitor for instance b.
  always @(posedge CLK) begin
    ack_t e;
    #1;
    if (!RESET && (b_cpu_ack || b_dma_ack)) begin
      if (qb_ack.size() == 0) begin
        fail("b_unexpected_ack");
      end else begin
        e = qb_ack.pop_front();
        chk("b_ack_sel", {b_dma_ack, b_cpu_ack},
            e.who ? 2'b10 : 2'b01);
        chk("b_dma_rdata", b_dma_rdata, e.dma_rd);
        chk("b_cpu_rdata", b_cpu_rdata, e.cpu_rd);
      end
    end
  end

  task automatic push_a(input logic who, input logic wr,
                        input logic [15:0] addr, input logic [7:0] wd,
                        input logic [7:0] rdv);
    ack_t e;
    cmd_t c;
    if (!wr) begin
      if (who) m_dma_rd = rdv;
      else     m_cpu_rd = rdv;
    end
    c.addr = addr; c.wr = wr; c.dout = wd;
    e.who = who; e.cpu_rd = m_cpu_rd; e.dma_rd = m_dma_rd;
    qa_cmd.push_back(c);
    qa_ack.push_back(e);
  endtask

  task automatic set_a(input logic who, input logic wr,
                       input logic [15:0] addr, input logic [7:0] wd);
    if (who) begin
      a_dma_req = 1'b1; a_dma_wr = wr;
      a_dma_addr = addr; a_dma_wdata = wd;
    end else begin
      a_cpu_req = 1'b1; a_cpu_wr = wr;
      a_cpu_addr = addr; a_cpu_wdata = wd;
    end
  endtask

  // Single access on instance a, checks the k+2+W latency.
  task automatic single_a(input logic who, input logic wr,
                          input logic [15:0] addr, input logic [7:0] wd,
                          input logic [7:0] rdv, input logic chg);
    int n;
    logic got;
    push_a(who, wr, addr, wd, rdv);
    @(negedge CLK);
    set_a(who, wr, addr, wd);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
      if (chg && n == 1) a_cpu_addr = 16'h1234;
      if (who ? a_dma_ack : a_cpu_ack) got = 1'b1;
    end
    if (!got) fail("a_ack_timeout");
    else chk("a_latency", n, W + 2);
    @(negedge CLK);
    a_cpu_req = 1'b0;
    a_dma_req = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    int n, k, last;
    ack_t e;
    cmd_t c;
    RESET = 1'b1;
    din_force = 1'b0; din_val = 8'h00;
    a_cpu_req = 0; a_cpu_wr = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
    a_dma_req = 0; a_dma_wr = 0; a_dma_addr = 0; a_dma_wdata = 0;
    b_cpu_req = 0; b_cpu_wr = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_dma_req = 0; b_dma_wr = 0; b_dma_addr = 0; b_dma_wdata = 0;
    m_cpu_rd = 8'h00;
    m_dma_rd = 8'h00;
    #12;
    chk("rst_strobes",
        {a_mem_mreq, a_mem_rd, a_mem_wr, a_mem_oe}, 0);
    chk("rst_acks", {a_cpu_ack, a_dma_ack}, 0);
    chk("rst_busy_owner", {a_busy, a_owner}, 0);
    chk("rst_addr_dout", {a_mem_addr, a_mem_dout}, 0);
    chk("rst_rdata", {a_cpu_rdata, a_dma_rdata}, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // 1: CPU read, forced data
    din_force = 1'b1; din_val = 8'hA5;
    single_a(1'b0, 1'b0, 16'h0150, 8'h00, 8'hA5, 1'b0);
    din_force = 1'b0;

    // 2: DMA write
    single_a(1'b1, 1'b1, 16'hFE00, 8'h3C, 8'h00, 1'b0);

    // 6: CPU addr changes during ADDR cycle
    single_a(1'b0, 1'b0, 16'h0100, 8'h00, mfn(16'h0100), 1'b1);

    // 3: round-robin tie, DMA read vs CPU write, 4 grants
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_a(1'b1, 1'b0, 16'h8000, 8'h00, mfn(16'h8000));
      else            push_a(1'b0, 1'b1, 16'h0200, 8'h11, 8'h00);
    end
    @(negedge CLK);
    set_a(1'b1, 1'b0, 16'h8000, 8'h00);
    set_a(1'b0, 1'b1, 16'h0200, 8'h11);
    n = 0; k = 0; last = 0;
    while (k < 4 && n < 80) begin
      @(posedge CLK);
      #1;
      n++;
      if (a_cpu_ack || a_dma_ack) begin
        if (k > 0) chk("a_rr_period", n - last, W + 3);
        last = n;
        k++;
      end
    end
    if (k < 4) fail("a_rr_timeout");
    @(negedge CLK);
    a_cpu_req = 1'b0;
    a_dma_req = 1'b0;
    repeat (2) @(negedge CLK);

    // 4: DMA priority tie on instance b
    for (int i = 0; i < 3; i++) begin
      e.who = 1'b1; e.cpu_rd = 8'h00; e.dma_rd = mfn(16'hC000);
      qb_ack.push_back(e);
    end
    b_dma_req = 1'b1; b_dma_wr = 1'b0; b_dma_addr = 16'hC000;
    b_cpu_req = 1'b1; b_cpu_wr = 1'b0; b_cpu_addr = 16'h0001;
    n = 0; k = 0;
    while (k < 3 && n < 80) begin
      @(posedge CLK);
      #1;
      n++;
      if (b_cpu_ack || b_dma_ack) k++;
    end
    if (k < 3) fail("b_prio_timeout");
    @(negedge CLK);
    b_cpu_req = 1'b0;
    b_dma_req = 1'b0;
    repeat (8) @(negedge CLK);

    // 5: reset during WAIT of a read
    din_force = 1'b1; din_val = 8'hFF;
    push_a(1'b0, 1'b0, 16'h0400, 8'h00, 8'hFF);
    @(negedge CLK);
    set_a(1'b0, 1'b0, 16'h0400, 8'h00);
    n = 0;
    while (!a_mem_rd && n < 20) begin
      @(posedge CLK);
      #1;
      n++;
    end
    if (!a_mem_rd) fail("a_rst_wait_timeout");
    #2;
    RESET = 1'b1;
    #1;
    chk("rst_mid_strobes", {a_mem_mreq, a_mem_rd, a_mem_oe}, 0);
    chk("rst_mid_ack", {a_cpu_ack, a_dma_ack}, 0);
    chk("rst_mid_rdata", a_cpu_rdata, 8'h00);
    a_cpu_req = 1'b0;
    e = qa_ack.pop_back();
    m_cpu_rd = 8'h00;
    m_dma_rd = 8'h00;
    din_force = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_busy", a_busy, 1'b0);
    single_a(1'b0, 1'b0, 16'h0300, 8'h00, mfn(16'h0300), 1'b0);

    repeat (4) @(negedge CLK);
    chk("qa_ack_left", qa_ack.size(), 0);
    chk("qa_cmd_left", qa_cmd.size(), 0);
    chk("qb_ack_left", qb_ack.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
